hilo_unit: RTL

- Downstream/companion stage of the 32x32 shift-add multiplier (`mul`) in the pipeline CPU EX stage.
- Conditions mult/multu operands, drives them to the unsigned multiplier, and waits a fixed multi-cycle latency.
- Sign-corrects the 64-bit product and writes the HI/LO architectural registers.
- Serves mfhi/mflo/mthi/mtlo and raises stall to the pipeline while a HI/LO hazard is pending.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/sign_fix.sv | 22 ++
 rtl/hilo_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the EX-stage HI/LO unit: opcode
//                encoding of HI/LO instructions, FSM state encoding, datapath
//                width and an opcode classification helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W = 32;

  // HI/LO opcode encoding; 7 is reserved and behaves as a NOP
  localparam logic [2:0] HILO_NOP   = 3'd0;
  localparam logic [2:0] HILO_MULT  = 3'd1;
  localparam logic [2:0] HILO_MULTU = 3'd2;
  localparam logic [2:0] HILO_MTHI  = 3'd3;
  localparam logic [2:0] HILO_MTLO  = 3'd4;
  localparam logic [2:0] HILO_MFHI  = 3'd5;
  localparam logic [2:0] HILO_MFLO  = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } hilo_state_t;

  // True for every opcode that touches HI/LO (and can therefore hazard)
  function automatic logic is_hilo_op(input logic [2:0] op);
    return (op >= HILO_MULT) && (op <= HILO_MFLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sign_fix.sv
`default_nettype none
// ============================================================================
//  Module      : sign_fix
//  Description : Combinational conditional two's-complement negate. Used as a
//                32-bit absolute value on multiplier operands (i_neg = sign
//                bit) and as a 64-bit sign correction on the product.
//  Revision    : 1.0 - initial release
// ============================================================================
module sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_data,
  input  logic         i_neg,
  output logic [W-1:0] o_data
);

  // Negate when requested; the most negative value maps to itself, which is
  // the correct unsigned magnitude for the multiplier.
  assign o_data = i_neg ? ((~i_data) + W'(1)) : i_data;

endmodule
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_unit
//  Description : EX-stage HI/LO unit. Conditions mult/multu operands for an
//                external unsigned multiplier, waits MUL_LATENCY cycles,
//                sign-corrects the 64-bit product into HI/LO, and serves
//                mfhi/mflo/mthi/mtlo with hazard stalls.
//  Options     : HILO_BYPASS_EN - forward the product to mfhi/mflo in the
//                capture cycle instead of stalling it.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_unit #(
  parameter int DATA_W      = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] op_src1,
  input  logic [DATA_W-1:0] op_src2,
  output logic [DATA_W-1:0] mlu_src1,
  output logic [DATA_W-1:0] mlu_src2,
  input  logic [DATA_W-1:0] mlu_result_l,
  input  logic [DATA_W-1:0] mlu_result_h,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              busy
);

  import cpu_pkg::*;

  localparam logic [3:0] c_CNT_INIT = 4'(MUL_LATENCY - 1);

  hilo_state_t         r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_neg;
  logic [DATA_W-1:0]   r_mlu_src1, r_mlu_src2;
  logic [DATA_W-1:0]   r_hi, r_lo;

  logic                w_idle, w_cap, w_stall;
  logic                w_op_mul, w_op_signed, w_op_hilo, w_op_mf;
  logic                w_op_mthi, w_op_mtlo;
  logic [DATA_W-1:0]   w_abs1, w_abs2, w_rd;
  logic [2*DATA_W-1:0] w_prod;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_cap       = (r_state == ST_MUL) && (r_cnt == 4'd0);
  assign w_op_signed = (op_code == HILO_MULT);
  assign w_op_mul    = op_valid && ((op_code == HILO_MULT) || (op_code == HILO_MULTU));
  assign w_op_hilo   = op_valid && is_hilo_op(op_code);
  assign w_op_mf     = op_valid && ((op_code == HILO_MFHI) || (op_code == HILO_MFLO));
  assign w_op_mthi   = w_idle && op_valid && (op_code == HILO_MTHI);
  assign w_op_mtlo   = w_idle && op_valid && (op_code == HILO_MTLO);

`ifdef HILO_BYPASS_EN
  // Reads can be satisfied from the product being captured this cycle
  assign w_stall = w_op_hilo && (r_state == ST_MUL) && !(w_cap && w_op_mf);
`else
  assign w_stall = w_op_hilo && (r_state == ST_MUL);
`endif

  // Operand magnitudes for MULT; MULTU passes operands unchanged
  sign_fix #(.W(DATA_W)) u_abs1 (
    .i_data (op_src1),
    .i_neg  (w_op_signed && op_src1[DATA_W-1]),
    .o_data (w_abs1)
  );

  sign_fix #(.W(DATA_W)) u_abs2 (
    .i_data (op_src2),
    .i_neg  (w_op_signed && op_src2[DATA_W-1]),
    .o_data (w_abs2)
  );

  // Restore the sign of the unsigned product
  sign_fix #(.W(2*DATA_W)) u_prod (
    .i_data ({mlu_result_h, mlu_result_l}),
    .i_neg  (r_neg),
    .o_data (w_prod)
  );

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: issue from IDLE, count down in MUL, return after capture
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_op_mul) begin
          w_state_nxt = ST_MUL;
          w_cnt_nxt   = c_CNT_INIT;
        end
      end
      ST_MUL: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch on issue; HI/LO written by capture or by mthi/mtlo
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mlu_src1 <= '0;
      r_mlu_src2 <= '0;
      r_neg      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      if (w_idle && w_op_mul) begin
        r_mlu_src1 <= w_abs1;
        r_mlu_src2 <= w_abs2;
        r_neg      <= w_op_signed && (op_src1[DATA_W-1] ^ op_src2[DATA_W-1]);
      end
      // mthi/mtlo only proceed in IDLE, so they never collide with capture
      if (w_cap) begin
        r_hi <= w_prod[2*DATA_W-1:DATA_W];
        r_lo <= w_prod[DATA_W-1:0];
      end else begin
        if (w_op_mthi) r_hi <= op_src1;
        if (w_op_mtlo) r_lo <= op_src1;
      end
    end
  end

  // Read port: registered HI/LO, or the product being captured this cycle
  always_comb begin
    w_rd = '0;
    if (op_valid && !w_stall) begin
      if (op_code == HILO_MFHI) begin
        w_rd = w_cap ? w_prod[2*DATA_W-1:DATA_W] : r_hi;
      end else if (op_code == HILO_MFLO) begin
        w_rd = w_cap ? w_prod[DATA_W-1:0] : r_lo;
      end
    end
  end

  assign mlu_src1 = r_mlu_src1;
  assign mlu_src2 = r_mlu_src2;
  assign rd_data  = w_rd;
  assign stall    = w_stall;
  assign busy     = (r_state == ST_MUL);

endmodule
`default_nettype wire
